// File: rtl/bp_be_pkg.sv
// Shared types and constants for the backend performance counter block.
// Holds the counter state encoding, the readback index map and config helpers.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_warmup = 2'd0,
    e_count  = 2'd1,
    e_done   = 2'd2
  } bp_be_perf_state_e;

  typedef enum int {
    e_bp_inv_cfg,
    e_bp_dual_core_cfg,
    e_bp_quad_core_cfg
  } bp_params_e;

  localparam int bp_be_perf_clk_idx_gp    = 0;
  localparam int bp_be_perf_instr_idx_gp  = 1;
  localparam int bp_be_perf_event_base_gp = 2;

  function automatic int bp_num_core(input bp_params_e cfg);
    case (cfg)
      e_bp_dual_core_cfg: return 2;
      e_bp_quad_core_cfg: return 4;
      default:            return 1;
    endcase
  endfunction

  // Width of an index over x items, never below one bit.
  function automatic int bsg_safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_be_perf_sat_counter.sv
// Saturating event counter with synchronous clear and a sticky overflow flag.
// An increment that would pass all-ones pins the count at all-ones instead.
module bp_be_perf_sat_counter #(
  parameter int width_p     = 64,
  parameter int amt_width_p = 1
) (
  input  logic                   clk_i,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [amt_width_p-1:0] amt_i,
  output logic [width_p-1:0]     count_o,
  output logic                   overflow_o
);

  logic [width_p-1:0] r_count;
  logic               r_overflow;
  logic [width_p:0]   w_sum;

  assign w_sum = {1'b0, r_count} + (width_p+1)'(amt_i);

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (en_i && (amt_i != '0)) begin
      if (w_sum[width_p]) begin
        r_count    <= '1;
        r_overflow <= 1'b1;
      end else begin
        r_count <= w_sum[width_p-1:0];
      end
    end
  end

  assign count_o    = r_count;
  assign overflow_o = r_overflow;

endmodule

// File: rtl/bp_be_nonsynth_perf_counters.sv
// Per-core performance counters: clk/instr/event counting after a warmup window,
// periodic instruction sampling, registered readback and an end-of-program report.
//
// state    | meaning
// e_warmup | skipping the first warmup_instr_p commits, nothing counts
// e_count  | all counters advance, sampling active
// e_done   | finish edge seen, counters frozen, report printed once
module bp_be_nonsynth_perf_counters
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int num_events_p      = 4,
  parameter int cnt_width_p       = 64,
  parameter int warmup_instr_p    = 0,
  parameter int sample_interval_p = 0,
  localparam int num_core_p    = bp_num_core(bp_params_p),
  localparam int hart_width_lp = bsg_safe_clog2(num_core_p),
  localparam int num_cnt_lp    = num_events_p + 2,
  localparam int idx_width_lp  = bsg_safe_clog2(num_cnt_lp)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     freeze_i,
  input  logic [hart_width_lp-1:0] mhartid_i,
  input  logic                     commit_v_i,
  input  logic [num_events_p-1:0]  event_v_i,
  input  logic [num_core_p-1:0]    program_finish_i,
  input  logic [idx_width_lp-1:0]  rd_idx_i,
  output logic [cnt_width_p-1:0]   rd_data_o,
  output logic [num_cnt_lp-1:0]    overflow_o,
  output logic                     sample_v_o,
  output logic [cnt_width_p-1:0]   sample_instr_o,
  output logic                     done_o
);

  localparam bp_be_perf_state_e entry_state_lp =
    bp_be_perf_state_e'((warmup_instr_p == 0) ? e_count : e_warmup);
  localparam int warm_width_lp = bsg_safe_clog2(warmup_instr_p + 1);
  localparam int warm_last_lp  = (warmup_instr_p > 0) ? warmup_instr_p - 1 : 0;

  bp_be_perf_state_e r_state;
  logic [warm_width_lp-1:0] r_warm;
  logic r_fin_prev;
  logic [cnt_width_p-1:0] r_rd_data;

  logic w_clear;
  logic w_count_en;
  logic w_fin_lvl;
  logic w_fin_edge;
  logic [(1<<hart_width_lp)-1:0] w_fin_vec;
  logic [num_cnt_lp-1:0] w_inc;
  logic [cnt_width_p-1:0] w_cnt [num_cnt_lp];
  logic [cnt_width_p-1:0] w_rd_sel;

  assign w_clear    = reset_i | freeze_i;
  assign w_count_en = (r_state == e_count);

  // Pad the finish vector so any hart id indexes safely; absent harts read 0.
  always_comb begin
    w_fin_vec = '0;
    w_fin_vec[num_core_p-1:0] = program_finish_i;
  end

  assign w_fin_lvl  = w_fin_vec[mhartid_i];
  assign w_fin_edge = w_fin_lvl & ~r_fin_prev;

  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_state    <= entry_state_lp;
      r_warm     <= '0;
      r_fin_prev <= 1'b0;
    end else begin
      r_fin_prev <= w_fin_lvl;
      case (r_state)
        e_warmup: begin
          if (w_fin_edge) begin
            r_state <= e_done;
          end else if (commit_v_i) begin
            r_warm <= r_warm + 1'b1;
            if (r_warm == warm_width_lp'(warm_last_lp)) r_state <= e_count;
          end
        end
        e_count: begin
          if (w_fin_edge) r_state <= e_done;
        end
        e_done: r_state <= e_done;
        default: r_state <= entry_state_lp;
      endcase
    end
  end

  assign done_o = (r_state == e_done);

  always_comb begin
    w_inc = '0;
    w_inc[bp_be_perf_clk_idx_gp]   = 1'b1;
    w_inc[bp_be_perf_instr_idx_gp] = commit_v_i;
    w_inc[bp_be_perf_event_base_gp +: num_events_p] = event_v_i;
  end

  for (genvar g = 0; g < num_cnt_lp; g++) begin : g_cnt
    bp_be_perf_sat_counter #(
      .width_p    (cnt_width_p),
      .amt_width_p(1)
    ) u_cnt (
      .clk_i     (clk_i),
      .clear_i   (w_clear),
      .en_i      (w_count_en),
      .amt_i     (w_inc[g]),
      .count_o   (w_cnt[g]),
      .overflow_o(overflow_o[g])
    );
  end

  always_comb begin
    w_rd_sel = '0;
    for (int k = 0; k < num_cnt_lp; k++) begin
      if (rd_idx_i == idx_width_lp'(k)) w_rd_sel = w_cnt[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_clear) r_rd_data <= '0;
    else         r_rd_data <= w_rd_sel;
  end

  assign rd_data_o = r_rd_data;

  if (sample_interval_p != 0) begin : g_samp
    localparam int samp_width_lp = bsg_safe_clog2(sample_interval_p + 1);

    logic [samp_width_lp-1:0] r_samp_left;
    logic [cnt_width_p-1:0]   r_instr_last;
    logic r_clk_moved;
    logic w_clk_adv;
    logic w_sample;

    // Down-counter of clk increments until the next interval boundary; it
    // freezes with clk, and r_clk_moved keeps a saturated clk from re-firing.
    assign w_clk_adv = w_count_en & ~(&w_cnt[bp_be_perf_clk_idx_gp]);
    assign w_sample  = w_count_en & r_clk_moved
                     & (r_samp_left == samp_width_lp'(sample_interval_p));

    always_ff @(posedge clk_i) begin
      if (w_clear) begin
        r_samp_left  <= samp_width_lp'(sample_interval_p);
        r_instr_last <= '0;
        r_clk_moved  <= 1'b0;
      end else begin
        r_clk_moved <= w_clk_adv;
        if (w_clk_adv) begin
          if (r_samp_left == samp_width_lp'(1)) r_samp_left <= samp_width_lp'(sample_interval_p);
          else                                  r_samp_left <= r_samp_left - 1'b1;
        end
        if (w_sample) r_instr_last <= w_cnt[bp_be_perf_instr_idx_gp];
      end
    end

    assign sample_v_o     = w_sample;
    assign sample_instr_o = w_sample ? (w_cnt[bp_be_perf_instr_idx_gp] - r_instr_last) : '0;
  end else begin : g_no_samp
    assign sample_v_o     = 1'b0;
    assign sample_instr_o = '0;
  end

`ifndef SYNTHESIS
  logic r_reported;
  logic [63:0] w_clk64;
  logic [63:0] w_instr64;
  logic [63:0] w_mipc;

  always_comb begin
    w_clk64   = 64'(w_cnt[bp_be_perf_clk_idx_gp]);
    w_instr64 = 64'(w_cnt[bp_be_perf_instr_idx_gp]);
    w_mipc    = (w_clk64 == 64'd0) ? 64'd0 : (w_instr64 * 64'd1000) / w_clk64;
  end

  // The report fires on the first e_done negedge; leaving e_done re-arms it.
  always_ff @(negedge clk_i) begin
    if (r_state != e_done) begin
      r_reported <= 1'b0;
    end else if (!r_reported) begin
      r_reported <= 1'b1;
      $display("[CORE%0d STATS] clk=%0d instr=%0d mIPC=%0d", mhartid_i, w_clk64, w_instr64, w_mipc);
      for (int k = 0; k < num_events_p; k++) begin
        $display("[CORE%0d STATS] event%0d=%0d", mhartid_i, k,
                 w_cnt[bp_be_perf_event_base_gp + k]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_nonsynth_perf_counters.sv
// Bench for the per-core performance counters: two configurations, a cycle model
// for the sampled instance with a sample scoreboard, constant checks for the other.
module tb_bp_be_nonsynth_perf_counters;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Instance A: 64-bit counters, no warmup, sample every 16 cycles
  logic        a_rst, a_frz, a_commit, a_sv, a_done;
  logic [0:0]  a_hart, a_fin;
  logic [3:0]  a_ev;
  logic [2:0]  a_idx;
  logic [63:0] a_rd, a_si;
  logic [5:0]  a_ovf;

  bp_be_nonsynth_perf_counters #(
    .num_events_p(4), .cnt_width_p(64), .warmup_instr_p(0), .sample_interval_p(16)
  ) u_dut_a (
    .clk_i(clk), .reset_i(a_rst), .freeze_i(a_frz), .mhartid_i(a_hart),
    .commit_v_i(a_commit), .event_v_i(a_ev), .program_finish_i(a_fin),
    .rd_idx_i(a_idx), .rd_data_o(a_rd), .overflow_o(a_ovf),
    .sample_v_o(a_sv), .sample_instr_o(a_si), .done_o(a_done)
  );

  // Instance B: 8-bit counters, 10-commit warmup, sampling off
  logic        b_rst, b_frz, b_commit, b_sv, b_done;
  logic [0:0]  b_hart, b_fin;
  logic [3:0]  b_ev;
  logic [2:0]  b_idx;
  logic [7:0]  b_rd, b_si;
  logic [5:0]  b_ovf;

  bp_be_nonsynth_perf_counters #(
    .num_events_p(4), .cnt_width_p(8), .warmup_instr_p(10), .sample_interval_p(0)
  ) u_dut_b (
    .clk_i(clk), .reset_i(b_rst), .freeze_i(b_frz), .mhartid_i(b_hart),
    .commit_v_i(b_commit), .event_v_i(b_ev), .program_finish_i(b_fin),
    .rd_idx_i(b_idx), .rd_data_o(b_rd), .overflow_o(b_ovf),
    .sample_v_o(b_sv), .sample_instr_o(b_si), .done_o(b_done)
  );

  // Reference model for A
  longint m_clk, m_instr, m_last;
  longint m_ev [4];
  bit     m_done, m_prev;
  longint q_samp [$];
  int     n_pop;

  task automatic tick_a(input bit rst, input bit frz, input bit commit,
                        input logic [3:0] ev, input bit fin);
    bit edge_v;
    a_rst = rst; a_frz = frz; a_commit = commit; a_ev = ev; a_fin = fin;
    @(posedge clk);
    if (rst || frz) begin
      m_clk = 0; m_instr = 0; m_last = 0; m_done = 0; m_prev = 0;
      for (int k = 0; k < 4; k++) m_ev[k] = 0;
    end else begin
      edge_v = fin && !m_prev;
      m_prev = fin;
      if (!m_done) begin
        m_clk++;
        if (commit) m_instr++;
        for (int k = 0; k < 4; k++) if (ev[k]) m_ev[k]++;
        if (edge_v) m_done = 1;
        else if (m_clk % 16 == 0) begin
          q_samp.push_back(m_instr - m_last);
          m_last = m_instr;
        end
      end
    end
    @(negedge clk);
    if (a_sv) begin
      n_pop++;
      if (q_samp.size() == 0) chk("samp_unexpected", 64'(a_sv), 64'd0);
      else chk("samp_instr", a_si, q_samp.pop_front());
    end
  endtask

  task automatic tick_b(input bit rst, input bit commit, input bit ev0, input bit fin);
    b_rst = rst; b_commit = commit; b_ev = {3'b000, ev0}; b_fin = fin;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd_b(input logic [2:0] idx, input string tag, input logic [63:0] exp);
    b_idx = idx;
    tick_b(1'b0, 1'b0, 1'b0, b_fin[0]);
    chk(tag, 64'(b_rd), exp);
  endtask

  initial begin
    logic [63:0] exp_v;
    a_rst = 1; a_frz = 0; a_commit = 0; a_ev = '0; a_fin = '0; a_idx = '0; a_hart = '0;
    b_rst = 1; b_frz = 0; b_commit = 0; b_ev = '0; b_fin = '0; b_idx = '0; b_hart = '0;
    n_pop = 0;

    // ---- A: 100 counting cycles, commit every other, finish at cycle 100
    tick_a(1, 0, 0, 4'h0, 0);
    tick_a(1, 0, 0, 4'h0, 0);
    chk("a_rst_done", 64'(a_done), 64'd0);
    chk("a_rst_rd", a_rd, 64'd0);
    chk("a_rst_ovf", 64'(a_ovf), 64'd0);
    chk("a_rst_sv", 64'(a_sv), 64'd0);
    chk("a_rst_si", a_si, 64'd0);
    for (int i = 1; i <= 100; i++) begin
      tick_a(0, 0, (i % 2 == 0), {(i % 5 == 0), 1'b0, (i % 3 == 0), 1'b1}, (i == 100));
      if (i == 50) chk("a_rd_latency", a_rd, 64'd49);
      if (i == 99) chk("a_done_pre", 64'(a_done), 64'd0);
    end
    chk("a_done_post", 64'(a_done), 64'd1);
    for (int k = 0; k < 8; k++) begin
      a_idx = 3'(k);
      tick_a(0, 0, 0, 4'h0, 1);
      case (k)
        0: exp_v = 64'(m_clk);
        1: exp_v = 64'(m_instr);
        2, 3, 4, 5: exp_v = 64'(m_ev[k-2]);
        default: exp_v = 64'd0;
      endcase
      chk($sformatf("a_sweep_idx%0d", k), a_rd, exp_v);
      if (k == 0) chk("a_clk_100", a_rd, 64'd100);
      if (k == 1) chk("a_instr_50", a_rd, 64'd50);
    end
    chk("a_ovf_none", 64'(a_ovf), 64'd0);
    chk("a_samples_p1", 64'(n_pop), 64'd6);

    // ---- A: reset coinciding with a finish edge, then a second finish
    tick_a(0, 0, 0, 4'h0, 0);
    chk("a_done_hold", 64'(a_done), 64'd1);
    tick_a(1, 0, 0, 4'h0, 1);
    chk("a_mid_rst_done", 64'(a_done), 64'd0);
    chk("a_mid_rst_rd", a_rd, 64'd0);
    chk("a_mid_rst_ovf", 64'(a_ovf), 64'd0);
    chk("a_mid_rst_sv", 64'(a_sv), 64'd0);
    chk("a_mid_rst_si", a_si, 64'd0);
    tick_a(0, 0, 1, 4'h0, 1);
    chk("a_done_second", 64'(a_done), 64'd1);
    a_idx = 3'd1;
    tick_a(0, 0, 0, 4'h0, 1);
    chk("a_instr_second", a_rd, 64'd1);
    a_idx = 3'd0;
    tick_a(0, 0, 0, 4'h0, 1);
    chk("a_clk_second", a_rd, 64'd1);

    // ---- A: sampling with a commit every cycle, then freeze
    tick_a(1, 0, 0, 4'h0, 0);
    n_pop = 0;
    for (int i = 1; i <= 50; i++) tick_a(0, 0, 1, 4'h0, 0);
    chk("a_samples_p3", 64'(n_pop), 64'd3);
    chk("a_samp_left", 64'(q_samp.size()), 64'd0);
    tick_a(0, 1, 1, 4'h0, 0);
    chk("a_frz_rd", a_rd, 64'd0);
    chk("a_frz_done", 64'(a_done), 64'd0);
    chk("a_frz_sv", 64'(a_sv), 64'd0);

    // ---- B: 10 warmup commits, then 20 counted cycles ending in finish
    tick_b(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick_b(0, 1, 1, 0);
    chk("b_warm_clk", 64'(b_rd), 64'd0);
    for (int i = 1; i <= 20; i++) tick_b(0, 1, 1, (i == 20));
    chk("b_done", 64'(b_done), 64'd1);
    rd_b(3'd0, "b_clk_20", 64'd20);
    rd_b(3'd1, "b_instr_20", 64'd20);
    rd_b(3'd2, "b_ev0_20", 64'd20);
    chk("b_ovf_none", 64'(b_ovf), 64'd0);

    // ---- B: event 0 held for 300 counting cycles saturates at 255
    tick_b(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick_b(0, 1, 0, 0);
    for (int i = 0; i < 300; i++) tick_b(0, 0, 1, 0);
    tick_b(0, 0, 1, 1);
    rd_b(3'd2, "b_ev0_sat", 64'd255);
    rd_b(3'd0, "b_clk_sat", 64'd255);
    rd_b(3'd1, "b_instr_zero", 64'd0);
    rd_b(3'd7, "b_idx_oor", 64'd0);
    chk("b_ovf_sat", 64'(b_ovf), 64'h05);

    // ---- B: warmup-completing commit coincides with finish edge
    tick_b(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick_b(0, 1, 1, 0);
    tick_b(0, 1, 1, 1);
    chk("b_coinc_done", 64'(b_done), 64'd1);
    rd_b(3'd0, "b_coinc_clk", 64'd0);
    rd_b(3'd1, "b_coinc_instr", 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
